// File: rtl/n101_icb_uart_v2_if.sv
// ICB command/response channel between the peripheral fabric (master) and the UART (slave).
interface n101_icb_uart_v2_if #(
   parameter int ADDR_W = 32
) ();
   logic              cmd_valid;
   logic              cmd_ready;
   logic [ADDR_W-1:0] cmd_addr;
   logic              cmd_read;
   logic [31:0]       cmd_wdata;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [31:0]       rsp_rdata;

   modport master (
      output cmd_valid, cmd_addr, cmd_read, cmd_wdata, rsp_ready,
      input  cmd_ready, rsp_valid, rsp_rdata
   );
   modport slave (
      input  cmd_valid, cmd_addr, cmd_read, cmd_wdata, rsp_ready,
      output cmd_ready, rsp_valid, rsp_rdata
   );
endinterface

// File: rtl/n101_icb_uart_v2.sv
// Native ICB-slave UART: TX/RX FIFOs, optional parity, 1/2 stop bits, sticky error flags, level IRQ.
// state   | meaning
// IDLE    | line idle; TX waits for txen and data, RX waits for a falling edge
// START   | start bit (RX: half-bit wait, then glitch check)
// DATA    | 8 data bits, LSB first
// PAR     | parity bit (only when parity enabled)
// STOP    | stop bit(s); TX 1 or 2, RX checks one
module n101_icb_uart_v2 #(
   parameter int               FIFO_DEPTH = 8,
   parameter int               DIV_W      = 16,
   parameter logic [DIV_W-1:0] DIV_RST    = DIV_W'(138),
   parameter int               ADDR_W     = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   n101_icb_uart_v2_if.slave     i_icb,
   output logic                  io_interrupts_0_0,
   output logic                  io_port_txd,
   input  logic                  io_port_rxd
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} uart_st_e;

   logic             rsp_valid_q, rsp_valid_d;
   logic [31:0]      rdata_q, rdata_d, rdata_mux;
   logic             txen_q, txen_d, nstop_q, nstop_d, rxen_q, rxen_d;
   logic [5:0]       txcnt_q, txcnt_d, rxcnt_q, rxcnt_d;
   logic [3:0]       ie_q, ie_d, ip;
   logic             rxovf_q, rxovf_d, parerr_q, parerr_d, irq_q, irq_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic             par_en_q, par_en_d, par_odd_q, par_odd_d;

   logic [7:0]       tx_mem [FIFO_DEPTH];
   logic [7:0]       rx_mem [FIFO_DEPTH];
   logic [CW-1:0]    tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d, rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
   logic [CW-1:0]    tx_count, rx_count;
   logic             tx_full, tx_empty, rx_full, rx_empty;
   logic             tx_push, tx_pop, rx_push_req, rx_push, rx_pop, rx_ovf_set, par_err_set;

   uart_st_e         tx_st_q, tx_st_d, rx_st_q, rx_st_d;
   logic [DIV_W-1:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d, rx_start_ld;
   logic [DIV_W:0]   rx_half;
   logic [2:0]       tx_bit_q, tx_bit_d, rx_bit_q, rx_bit_d;
   logic [7:0]       tx_data_q, tx_data_d, rx_sh_q, rx_sh_d;
   logic             tx_stop2_q, tx_stop2_d, txd_q, txd_d, rx_bad_q, rx_bad_d;
   logic             rx_s1_q, rx_s2_q, rx_s3_q;
   logic             cmd_acc, wr, rd, tx_tc, rx_tc, rx_fall;
   logic [2:0]       sel;
   logic             unused_bits;

   assign unused_bits        = ^{i_icb.cmd_addr[ADDR_W-1:0], i_icb.cmd_wdata};
   assign i_icb.cmd_ready    = ~rsp_valid_q | i_icb.rsp_ready;
   assign i_icb.rsp_valid    = rsp_valid_q;
   assign i_icb.rsp_rdata    = rdata_q;
   assign io_interrupts_0_0  = irq_q;
   assign io_port_txd        = txd_q;

   assign cmd_acc  = i_icb.cmd_valid & i_icb.cmd_ready;
   assign wr       = cmd_acc & ~i_icb.cmd_read;
   assign rd       = cmd_acc & i_icb.cmd_read;
   assign sel      = i_icb.cmd_addr[4:2];

   assign tx_count = tx_wp_q - tx_rp_q;
   assign rx_count = rx_wp_q - rx_rp_q;
   assign tx_full  = (tx_count == CW'(FIFO_DEPTH));
   assign rx_full  = (rx_count == CW'(FIFO_DEPTH));
   assign tx_empty = (tx_count == '0);
   assign rx_empty = (rx_count == '0);
   assign tx_push  = wr & (sel == 3'd0) & (~tx_full | tx_pop);
   assign rx_pop   = rd & (sel == 3'd1) & ~rx_empty;
   assign rx_push  = rx_push_req & (~rx_full | rx_pop);
   assign rx_ovf_set = rx_push_req & rx_full & ~rx_pop;

   assign ip = {parerr_q, rxovf_q, int'(rx_count) > int'(rxcnt_q), int'(tx_count) < int'(txcnt_q)};

   assign tx_tc   = (tx_cnt_q == '0);
   assign rx_tc   = (rx_cnt_q == '0);
   assign rx_fall = rx_s3_q & ~rx_s2_q;
   // Half-bit wait so later samples land mid-bit.
   assign rx_half     = ({1'b0, div_q} + {{DIV_W{1'b0}}, 1'b1}) >> 1;
   assign rx_start_ld = (rx_half == '0) ? '0 : DIV_W'(rx_half - 1'b1);

   always_ff @(posedge clk) begin
      if (tx_push) tx_mem[tx_wp_q[AW-1:0]] <= i_icb.cmd_wdata[7:0];
      if (rx_push) rx_mem[rx_wp_q[AW-1:0]] <= rx_sh_q;
   end

   always_comb begin
      rdata_mux = '0;
      case (sel)
         3'd0: rdata_mux[31] = tx_full;
         3'd1: rdata_mux = {rx_empty, 23'b0, rx_mem[rx_rp_q[AW-1:0]]};
         3'd2: rdata_mux = {10'b0, txcnt_q, 14'b0, nstop_q, txen_q};
         3'd3: rdata_mux = {10'b0, rxcnt_q, 15'b0, rxen_q};
         3'd4: rdata_mux[3:0] = ie_q;
         3'd5: rdata_mux[3:0] = ip;
         3'd6: rdata_mux[DIV_W-1:0] = div_q;
         default: rdata_mux[1:0] = {par_odd_q, par_en_q};
      endcase
   end

   always_comb begin
      rsp_valid_d = rsp_valid_q;
      rdata_d     = rdata_q;
      txen_d = txen_q;  nstop_d = nstop_q;  txcnt_d = txcnt_q;
      rxen_d = rxen_q;  rxcnt_d = rxcnt_q;  ie_d = ie_q;  div_d = div_q;
      par_en_d = par_en_q;  par_odd_d = par_odd_q;
      rxovf_d  = rxovf_q;
      parerr_d = parerr_q;
      if (cmd_acc) begin
         rsp_valid_d = 1'b1;
         rdata_d     = i_icb.cmd_read ? rdata_mux : '0;
      end else if (i_icb.rsp_ready) begin
         rsp_valid_d = 1'b0;
      end
      if (wr) begin
         case (sel)
            3'd2: begin txen_d = i_icb.cmd_wdata[0]; nstop_d = i_icb.cmd_wdata[1]; txcnt_d = i_icb.cmd_wdata[21:16]; end
            3'd3: begin rxen_d = i_icb.cmd_wdata[0]; rxcnt_d = i_icb.cmd_wdata[21:16]; end
            3'd4: ie_d = i_icb.cmd_wdata[3:0];
            3'd5: begin rxovf_d = rxovf_q & ~i_icb.cmd_wdata[2]; parerr_d = parerr_q & ~i_icb.cmd_wdata[3]; end
            3'd6: div_d = i_icb.cmd_wdata[DIV_W-1:0];
            3'd7: begin par_en_d = i_icb.cmd_wdata[0]; par_odd_d = i_icb.cmd_wdata[1]; end
            default: ;
         endcase
      end
      // A new error in the same cycle as a clear wins.
      rxovf_d  = rxovf_d | rx_ovf_set;
      parerr_d = parerr_d | par_err_set;
      irq_d    = |(ie_q & ip);
      tx_wp_d  = tx_wp_q + CW'(tx_push);
      tx_rp_d  = tx_rp_q + CW'(tx_pop);
      rx_wp_d  = rx_wp_q + CW'(rx_push);
      rx_rp_d  = rx_rp_q + CW'(rx_pop);
   end

   always_comb begin
      tx_st_d = tx_st_q;  tx_cnt_d = tx_cnt_q;  tx_bit_d = tx_bit_q;
      tx_data_d = tx_data_q;  tx_stop2_d = tx_stop2_q;  txd_d = txd_q;
      tx_pop = 1'b0;
      case (tx_st_q)
         S_IDLE: begin
            txd_d = 1'b1;
            if (txen_q && !tx_empty) begin
               tx_pop = 1'b1;  tx_data_d = tx_mem[tx_rp_q[AW-1:0]];
               tx_st_d = S_START;  tx_cnt_d = div_q;  txd_d = 1'b0;
            end
         end
         S_START: if (tx_tc) begin
            tx_st_d = S_DATA;  tx_cnt_d = div_q;  tx_bit_d = 3'd0;  txd_d = tx_data_q[0];
         end else tx_cnt_d = tx_cnt_q - 1'b1;
         S_DATA: if (tx_tc) begin
            tx_cnt_d = div_q;
            if (tx_bit_q == 3'd7) begin
               if (par_en_q) begin tx_st_d = S_PAR;  txd_d = ^tx_data_q ^ par_odd_q; end
               else begin tx_st_d = S_STOP;  txd_d = 1'b1;  tx_stop2_d = nstop_q; end
            end else begin
               tx_bit_d = tx_bit_q + 3'd1;  txd_d = tx_data_q[tx_bit_q + 3'd1];
            end
         end else tx_cnt_d = tx_cnt_q - 1'b1;
         S_PAR: if (tx_tc) begin
            tx_st_d = S_STOP;  tx_cnt_d = div_q;  txd_d = 1'b1;  tx_stop2_d = nstop_q;
         end else tx_cnt_d = tx_cnt_q - 1'b1;
         S_STOP: if (tx_tc) begin
            if (tx_stop2_q) begin tx_stop2_d = 1'b0;  tx_cnt_d = div_q; end
            else tx_st_d = S_IDLE;
         end else tx_cnt_d = tx_cnt_q - 1'b1;
         default: begin tx_st_d = S_IDLE;  txd_d = 1'b1; end
      endcase
   end

   always_comb begin
      rx_st_d = rx_st_q;  rx_cnt_d = rx_cnt_q;  rx_bit_d = rx_bit_q;
      rx_sh_d = rx_sh_q;  rx_bad_d = rx_bad_q;
      rx_push_req = 1'b0;  par_err_set = 1'b0;
      case (rx_st_q)
         S_IDLE: if (rxen_q && rx_fall) begin rx_st_d = S_START;  rx_cnt_d = rx_start_ld; end
         S_START: if (rx_tc) begin
            if (rx_s2_q) rx_st_d = S_IDLE;
            else begin rx_st_d = S_DATA;  rx_cnt_d = div_q;  rx_bit_d = 3'd0;  rx_bad_d = 1'b0; end
         end else rx_cnt_d = rx_cnt_q - 1'b1;
         S_DATA: if (rx_tc) begin
            rx_sh_d = {rx_s2_q, rx_sh_q[7:1]};  rx_cnt_d = div_q;
            if (rx_bit_q == 3'd7) rx_st_d = par_en_q ? S_PAR : S_STOP;
            else rx_bit_d = rx_bit_q + 3'd1;
         end else rx_cnt_d = rx_cnt_q - 1'b1;
         S_PAR: if (rx_tc) begin
            rx_bad_d    = rx_s2_q != (^rx_sh_q ^ par_odd_q);
            par_err_set = rx_bad_d;
            rx_st_d = S_STOP;  rx_cnt_d = div_q;
         end else rx_cnt_d = rx_cnt_q - 1'b1;
         S_STOP: if (rx_tc) begin
            rx_st_d = S_IDLE;
            rx_push_req = rx_s2_q & ~rx_bad_q;
         end else rx_cnt_d = rx_cnt_q - 1'b1;
         default: rx_st_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_valid_q <= 1'b0;  rdata_q <= '0;
         txen_q <= 1'b0;  nstop_q <= 1'b0;  txcnt_q <= '0;  rxen_q <= 1'b0;  rxcnt_q <= '0;
         ie_q <= '0;  rxovf_q <= 1'b0;  parerr_q <= 1'b0;  irq_q <= 1'b0;  div_q <= DIV_RST;
         par_en_q <= 1'b0;  par_odd_q <= 1'b0;
         tx_wp_q <= '0;  tx_rp_q <= '0;  rx_wp_q <= '0;  rx_rp_q <= '0;
         tx_st_q <= S_IDLE;  tx_cnt_q <= '0;  tx_bit_q <= '0;  tx_data_q <= '0;
         tx_stop2_q <= 1'b0;  txd_q <= 1'b1;
         rx_st_q <= S_IDLE;  rx_cnt_q <= '0;  rx_bit_q <= '0;  rx_sh_q <= '0;  rx_bad_q <= 1'b0;
         rx_s1_q <= 1'b1;  rx_s2_q <= 1'b1;  rx_s3_q <= 1'b1;
      end else begin
         rsp_valid_q <= rsp_valid_d;  rdata_q <= rdata_d;
         txen_q <= txen_d;  nstop_q <= nstop_d;  txcnt_q <= txcnt_d;  rxen_q <= rxen_d;  rxcnt_q <= rxcnt_d;
         ie_q <= ie_d;  rxovf_q <= rxovf_d;  parerr_q <= parerr_d;  irq_q <= irq_d;  div_q <= div_d;
         par_en_q <= par_en_d;  par_odd_q <= par_odd_d;
         tx_wp_q <= tx_wp_d;  tx_rp_q <= tx_rp_d;  rx_wp_q <= rx_wp_d;  rx_rp_q <= rx_rp_d;
         tx_st_q <= tx_st_d;  tx_cnt_q <= tx_cnt_d;  tx_bit_q <= tx_bit_d;  tx_data_q <= tx_data_d;
         tx_stop2_q <= tx_stop2_d;  txd_q <= txd_d;
         rx_st_q <= rx_st_d;  rx_cnt_q <= rx_cnt_d;  rx_bit_q <= rx_bit_d;  rx_sh_q <= rx_sh_d;  rx_bad_q <= rx_bad_d;
         rx_s1_q <= io_port_rxd;  rx_s2_q <= rx_s1_q;  rx_s3_q <= rx_s2_q;
      end
   end
endmodule
